// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/seq_det_core.sv
// Pattern history, fill tracking and combinational compare for the detector.
module seq_det_core #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             din,
  input  logic             din_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window;
  logic              shift;

  assign window = {hist, din};
  assign shift  = enable && din_valid;
  assign match  = shift && (fill == FILL_MAX) && (window == pattern);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= window[PAT_W-2:0];
      // Non-overlapping mode forgets the matched bits so none can be reused.
      if (match && !overlap)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Detector top: config handshake, run-control FSM and saturating match counter.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pattern_q;
  logic             overlap_q;
  logic [CNT_W-1:0] limit_q;
  logic             cfg_fire;
  logic             go_run;
  logic             match;
  logic             core_en;
  logic             hit_limit;

  assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign dout      = match;
  // Gating with abort suppresses a match that coincides with termination.
  assign core_en   = (state_q == RUN) && !abort;
  assign hit_limit = (limit_q != '0) && ((match_cnt + CNT_W'(1)) == limit_q);

  seq_det_core #(.PAT_W(PAT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .enable    (core_en),
    .clear     (go_run),
    .din       (din),
    .din_valid (din_valid),
    .pattern   (pattern_q),
    .overlap   (overlap_q),
    .match     (match)
  );

  always_comb begin
    state_d = state_q;
    go_run  = 1'b0;
    case (state_q)
      IDLE:  if (cfg_fire) state_d = ARMED;
      ARMED: begin
        if (abort) state_d = IDLE;
        else if (start) begin
          state_d = RUN;
          go_run  = 1'b1;
        end
      end
      RUN: begin
        if (abort) state_d = IDLE;
        else if (match && hit_limit) state_d = DONE;
      end
      DONE: begin
        // An accepted config transfer takes priority over a restart.
        if (cfg_fire) state_d = ARMED;
        else if (abort) state_d = IDLE;
        else if (start) begin
          state_d = RUN;
          go_run  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= '0;
      overlap_q <= 1'b0;
      limit_q   <= '0;
    end else if (cfg_fire) begin
      pattern_q <= cfg_pattern;
      overlap_q <= cfg_overlap;
      limit_q   <= cfg_limit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      match_cnt <= '0;
    else if (go_run)
      match_cnt <= '0;
    else if (match && !((limit_q == '0) && (&match_cnt)))
      match_cnt <= match_cnt + CNT_W'(1);
  end

endmodule
